// File: rtl/fault_diag_pkg.sv
// rtl/fault_diag_pkg.sv - state encoding and default sizes for the fault-dictionary diagnoser
package fault_diag_pkg;

  localparam int TEST_COUNT_DEF  = 66;
  localparam int FAULT_COUNT_DEF = 980;
  localparam int IDX_W_DEF       = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    SCAN    = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } diag_state_t;

endpackage

// File: rtl/fault_diagnoser_if.sv
// rtl/fault_diagnoser_if.sv - tester, dictionary and result signals of the fault diagnoser
interface fault_diagnoser_if #(
  parameter int TEST_COUNT = fault_diag_pkg::TEST_COUNT_DEF,
  parameter int IDX_W      = fault_diag_pkg::IDX_W_DEF
);

  logic                  start;
  logic                  pf_valid;
  logic                  pf_fail;
  logic                  pf_ready;
  logic                  dict_rd;
  logic [IDX_W-1:0]      dict_addr;
  logic [TEST_COUNT-1:0] dict_data;
  logic                  busy;
  logic                  done;
  logic                  fault_free;
  logic                  match_found;
  logic [IDX_W-1:0]      match_count;
  logic [IDX_W-1:0]      first_idx;
  logic [TEST_COUNT-1:0] syndrome;

  modport master (
    output start, pf_valid, pf_fail, dict_data,
    input  pf_ready, dict_rd, dict_addr, busy, done, fault_free,
           match_found, match_count, first_idx, syndrome
  );

  modport slave (
    input  start, pf_valid, pf_fail, dict_data,
    output pf_ready, dict_rd, dict_addr, busy, done, fault_free,
           match_found, match_count, first_idx, syndrome
  );

endinterface

// File: rtl/syndrome_collector.sv
// rtl/syndrome_collector.sv - pass/fail handshake, pattern index and syndrome register with zero detect
module syndrome_collector #(
  parameter int TEST_COUNT = fault_diag_pkg::TEST_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  pf_valid_i,
  input  logic                  pf_fail_i,
  output logic                  pf_ready_o,
  output logic                  last_xfer_o,
  output logic                  all_zero_o,
  output logic [TEST_COUNT-1:0] syndrome_o
);

  localparam int               CNT_W    = $clog2(TEST_COUNT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TEST_COUNT - 1);

  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [TEST_COUNT-1:0] syn_q, syn_d;
  logic                  xfer;

  assign pf_ready_o  = enable_i;
  assign xfer        = pf_valid_i & enable_i;
  assign last_xfer_o = xfer && (idx_q == LAST_IDX);
  // The last bit is still on the input during its transfer, so fold it into the zero test.
  assign all_zero_o  = (syn_q == '0) && !pf_fail_i;
  assign syndrome_o  = syn_q;

  always_comb begin
    idx_d = idx_q;
    syn_d = syn_q;
    if (clear_i) begin
      idx_d = '0;
      syn_d = '0;
    end else if (xfer) begin
      syn_d[idx_q] = pf_fail_i;
      idx_d        = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      syn_q <= '0;
    end else begin
      idx_q <= idx_d;
      syn_q <= syn_d;
    end
  end

endmodule

// File: rtl/fault_diagnoser.sv
// rtl/fault_diagnoser.sv - collects a pass/fail syndrome and counts matching fault-dictionary entries
module fault_diagnoser
  import fault_diag_pkg::*;
#(
  parameter int TEST_COUNT  = TEST_COUNT_DEF,
  parameter int FAULT_COUNT = FAULT_COUNT_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input logic               clk,
  input logic               rst,
  fault_diagnoser_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(FAULT_COUNT - 1);

  diag_state_t           state_q, state_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic [IDX_W-1:0]      addr_pipe_q;
  logic                  rd_pipe_q;
  logic [IDX_W-1:0]      match_count_q, match_count_d;
  logic [IDX_W-1:0]      first_idx_q, first_idx_d;
  logic                  fault_free_q, fault_free_d;
  logic                  done_q;
  logic                  clear;
  logic                  last_xfer;
  logic                  all_zero;
  logic                  entry_match;
  logic                  pf_ready;
  logic [TEST_COUNT-1:0] syndrome;

  syndrome_collector #(
    .TEST_COUNT (TEST_COUNT)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .enable_i    (state_q == COLLECT),
    .pf_valid_i  (bus.pf_valid),
    .pf_fail_i   (bus.pf_fail),
    .pf_ready_o  (pf_ready),
    .last_xfer_o (last_xfer),
    .all_zero_o  (all_zero),
    .syndrome_o  (syndrome)
  );

  // Dictionary data arrives one cycle after its read; rd_pipe_q/addr_pipe_q tag that cycle.
  assign entry_match = rd_pipe_q && (bus.dict_data == syndrome);

  always_comb begin
    state_d       = state_q;
    clear         = 1'b0;
    addr_d        = addr_q;
    match_count_d = match_count_q;
    first_idx_d   = first_idx_q;
    fault_free_d  = fault_free_q;

    if (entry_match) begin
      match_count_d = match_count_q + IDX_W'(1);
      if (match_count_q == '0) begin
        first_idx_d = addr_pipe_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d       = COLLECT;
          clear         = 1'b1;
          addr_d        = '0;
          match_count_d = '0;
          first_idx_d   = '0;
          fault_free_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (last_xfer) begin
          if (all_zero) begin
            state_d      = DONE;
            fault_free_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      addr_pipe_q   <= '0;
      rd_pipe_q     <= 1'b0;
      match_count_q <= '0;
      first_idx_q   <= '0;
      fault_free_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      addr_pipe_q   <= addr_q;
      rd_pipe_q     <= (state_q == SCAN);
      match_count_q <= match_count_d;
      first_idx_q   <= first_idx_d;
      fault_free_q  <= fault_free_d;
      done_q        <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign bus.pf_ready    = pf_ready;
  assign bus.dict_rd     = (state_q == SCAN);
  assign bus.dict_addr   = addr_q;
  assign bus.busy        = (state_q == COLLECT) || (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done        = done_q;
  assign bus.fault_free  = fault_free_q;
  assign bus.match_found = (match_count_q != '0);
  assign bus.match_count = match_count_q;
  assign bus.first_idx   = first_idx_q;
  assign bus.syndrome    = syndrome;

endmodule
